// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio receive/transmit path.
// No logic; elaborated at compile time only.
// Not applicable: no handshake.
package audio_pkg;

    localparam int PCM_W        = 16;
    localparam int CIC_ORDER    = 2;
    localparam int WARMUP_TICKS = 2;

    // Integrator width needed so that a full window sum of D^ORDER fits plus one guard bit.
    function automatic int cic_width(input int log2_decim);
        return CIC_ORDER * log2_decim + 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk cycles.
// Backpressure: none; samples every cycle.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// PDM to unsigned PCM via 2nd-order CIC decimation by 2^LOG2_DECIM.
// Latency: sample registered 1 cycle after each decimation tick (plus 2-cycle input sync).
// Backpressure: one-entry valid/ready register; unaccepted samples are replaced and flag sticky overrun.
module pdm_decimator
    import audio_pkg::*;
#(
    parameter int LOG2_DECIM = 8,
    parameter int OUT_WIDTH  = PCM_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pdm_in,
    output logic [OUT_WIDTH-1:0] pcm,
    output logic                 pcm_valid,
    input  logic                 pcm_ready,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int W      = cic_width(LOG2_DECIM);
    localparam int PROD_W = 2 * LOG2_DECIM;
    localparam logic [W-1:0] R_MAX = W'((1 << PROD_W) - 1);

    logic                  s;
    logic [LOG2_DECIM-1:0] cnt;
    logic                  tick;
    logic [W-1:0]          i1, i2, i2_d, c1_d;
    logic [W-1:0]          c1, c2, rs;
    logic [1:0]            warm;
    logic                  load;
    logic                  accept;
    logic                  ovr_set;
    logic [OUT_WIDTH-1:0]  pcm_next;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pdm_in),
        .q     (s)
    );

    assign tick = &cnt;
    assign c1   = i2 - i2_d;
    assign c2   = c1 - c1_d;
    // A full-scale window yields exactly D^2, one past the output range.
    assign rs   = (c2 > R_MAX) ? R_MAX : c2;

    if (PROD_W >= OUT_WIDTH) begin : g_shr
        assign pcm_next = OUT_WIDTH'(rs >> (PROD_W - OUT_WIDTH));
    end else begin : g_shl
        assign pcm_next = OUT_WIDTH'({rs, {(OUT_WIDTH - PROD_W){1'b0}}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            i1   <= '0;
            i2   <= '0;
            i2_d <= '0;
            c1_d <= '0;
            warm <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            i1  <= i1 + W'(s);
            i2  <= i2 + i1;
            if (tick) begin
                i2_d <= i2;
                c1_d <= c1;
                if (warm != 2'(WARMUP_TICKS)) begin
                    warm <= warm + 2'd1;
                end
            end
        end
    end

    // The first ticks after reset see partially filled combs, so they are dropped.
    assign load    = tick && (warm == 2'(WARMUP_TICKS));
    assign accept  = pcm_valid && pcm_ready;
    assign ovr_set = load && pcm_valid && !pcm_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm       <= '0;
            pcm_valid <= 1'b0;
        end else if (load) begin
            pcm       <= pcm_next;
            pcm_valid <= 1'b1;
        end else if (accept) begin
            pcm_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= ovr_set | (overrun & ~overrun_clr);
        end
    end

endmodule
